prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
//  - Parametrised up/down modulo counter with prescaler, sync load/clear, and wrap or saturate mode.
//  - Generalises the 4-bit up counter for lab timers and event counters.
//  - Fed by lab control logic (switches/PS registers). Drives LEDs, timers and interrupt pulses.
// PARAMETERS
//  - WIDTH    8             counter width in bits (>=2)
//  - MAX_VAL  2**WIDTH-1    terminal value; counts 0..MAX_VAL; requires 1 <= MAX_VAL <= 2**WIDTH-1
//  - PS_W     8             prescale register width (>=1)
// PORTS
//  - clk        in   1      clock
//  - rst_n      in   1      asynchronous, active-low reset
//  - clear      in   1      sync clear of count and prescaler
//  - enable     in   1      count enable; prescaler advances only while high
//  - up_dn      in   1      1 = count up, 0 = count down
//  - mode       in   1      cnt_mode_e: CM_WRAP=0, CM_SAT=1
//  - load       in   1      sync load of load_val
//  - load_val   in   WIDTH  load value; values > MAX_VAL clamp to MAX_VAL
//  - prescale   in   PS_W   step once per (prescale+1) enabled cycles; 0 = every enabled cycle
//  - count      out  WIDTH  current count (registered)
//  - tc         out  1      comb terminal count: (up_dn && count==MAX_VAL) || (!up_dn && count==0)
//  - overflow   out  1      registered 1-cycle pulse: up-step attempted at MAX_VAL
//  - underflow  out  1      registered 1-cycle pulse: down-step attempted at 0
// BEHAVIOUR
//  - Reset: count=0, prescaler count=0, overflow=0, underflow=0. Takes effect immediately, including mid-operation.
//  - Per-cycle priority: clear > load > step > hold.
//  - clear: count<=0, ps_cnt<=0, overflow/underflow<=0.
//  - load: count<=min(load_val,MAX_VAL), ps_cnt<=0, overflow/underflow<=0.
//  - Prescaler ps_cnt[PS_W]:
//    - enable=1 and ps_cnt==prescale: tick; ps_cnt<=0.
//    - enable=1 otherwise: ps_cnt<=ps_cnt+1.
//    - enable=0: ps_cnt holds.
//    - If prescale is lowered below ps_cnt: ps_cnt advances and wraps at 2**PS_W, then ticks on the next match (no special case).
//  - Step, on tick only:
//    - Up, count<MAX_VAL: count+1.
//    - Up at MAX_VAL: overflow<=1. CM_WRAP: count<=0. CM_SAT: hold.
//    - Down, count>0: count-1.
//    - Down at 0: underflow<=1. CM_WRAP: count<=MAX_VAL. CM_SAT: hold.
//  - overflow/underflow are 0 on every cycle without a qualifying step. Never both high.
//  - Latency: count, overflow and underflow update on the clock edge that samples the tick (1 cycle). tc is combinational from count and up_dn.
//  - up_dn and mode are sampled per tick and may change at any cycle with no glitch on count.
//  - Arithmetic is done in WIDTH bits. The compare is against MAX_VAL cast to WIDTH bits. No intermediate overflow.
// STRUCTURE
//  - Package prog_counter_pkg: typedef enum logic {CM_WRAP, CM_SAT} cnt_mode_e.
//  - Sub-module prog_prescaler (PS_W): ports clk, rst_n, clr, enable, prescale; output tick.
//  - Top level: clamp logic, next-count mux, flag registers, tc decode.
// TESTING
//  - T1 (WIDTH=4, MAX_VAL=9, CM_WRAP, up, prescale=0, enable 10 cycles from 0)
//      -> count 1..9 then 0; overflow high only on the cycle count=0; tc high while count=9.
//  - T2 (CM_SAT, down, load 2, then 4 enabled cycles)
//      -> count 1,0,0,0; underflow pulses on cycles 3 and 4; count never wraps.
//  - T3 (prescale=3, up, enable 8 cycles, drop enable 2 cycles mid-way, resume)
//      -> step every 4th enabled cycle; no step or ps advance while disabled.
//  - T4 (load_val=12 with MAX_VAL=9) -> count=9.
//       (load and clear in the same cycle) -> count=0.
//       (load on the same cycle as a tick) -> loaded value wins; no flag pulse.
//  - T5 (assert rst_n=0 asynchronously with count=7 and overflow pulsing)
//      -> count=0, flags=0 before the next clk edge; counting resumes from 0 after release.
//  - T6 (CM_WRAP, down from 0, prescale=0)
//      -> count=MAX_VAL with underflow pulse; switch mode to CM_SAT at count=0 -> holds at 0.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable up/down counter.
package prog_counter_pkg;

    typedef enum logic {
        CM_WRAP = 1'b0,
        CM_SAT  = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/prog_prescaler.sv
// Tick generator: one tick every (prescale+1) enabled cycles; tick is combinational from ps_cnt.
// clr restarts the phase; ps_cnt holds while enable is low.
module prog_prescaler #(
    parameter int PS_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            enable,
    input  logic [PS_W-1:0] prescale,
    output logic            tick
);

    logic [PS_W-1:0] ps_cnt;

    assign tick = enable && (ps_cnt == prescale);

    // A prescale lowered below ps_cnt simply lets ps_cnt run round to the next match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (clr) begin
            ps_cnt <= '0;
        end else if (enable) begin
            if (ps_cnt == prescale) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Up/down modulo counter with prescaler, sync clear/load and wrap/saturate on the terminal value.
// count/overflow/underflow update on the ticking edge (1 cycle); tc is combinational; no backpressure.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int PS_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_dn,
    input  cnt_mode_e        mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic             tick;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;
    logic             overflow_nxt;
    logic             underflow_nxt;

    prog_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear | load),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
    assign tc           = up_dn ? (count == MAX_C) : (count == '0);

    always_comb begin
        count_nxt     = count;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = load_clamped;
        end else if (tick) begin
            if (up_dn) begin
                if (count == MAX_C) begin
                    overflow_nxt = 1'b1;
                    if (mode == CM_WRAP) count_nxt = '0;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    underflow_nxt = 1'b1;
                    if (mode == CM_WRAP) count_nxt = MAX_C;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Directed scenarios plus randomized traffic against an integer reference model of the counter.
module tb_prog_counter;
    import prog_counter_pkg::*;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;
    localparam int PS_W    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             enable;
    logic             up_dn;
    cnt_mode_e        mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [PS_W-1:0]  prescale;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             overflow;
    logic             underflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_count = 0;
    int m_ps    = 0;
    int m_ovf   = 0;
    int m_unf   = 0;

    always #5 clk = ~clk;

    prog_counter #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .PS_W    (PS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .enable    (enable),
        .up_dn     (up_dn),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .prescale  (prescale),
        .count     (count),
        .tc        (tc),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_ps    = 0;
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    // One clock edge of the counter's rules, using the inputs currently applied.
    task automatic model_step();
        bit stepping;
        m_ovf    = 0;
        m_unf    = 0;
        stepping = 0;
        if (clear) begin
            m_count = 0;
            m_ps    = 0;
        end else if (load) begin
            m_count = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
            m_ps    = 0;
        end else if (enable) begin
            if (m_ps == int'(prescale)) begin
                stepping = 1;
                m_ps     = 0;
            end else begin
                m_ps = (m_ps + 1) % (1 << PS_W);
            end
        end
        if (stepping) begin
            if (up_dn) begin
                if (m_count < MAX_VAL)      m_count = m_count + 1;
                else begin
                    m_ovf = 1;
                    if (mode == CM_WRAP) m_count = 0;
                end
            end else begin
                if (m_count > 0)            m_count = m_count - 1;
                else begin
                    m_unf = 1;
                    if (mode == CM_WRAP) m_count = MAX_VAL;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_tc;
        exp_tc = up_dn ? int'(m_count == MAX_VAL) : int'(m_count == 0);
        check({tag, "_count"}, int'(count), m_count);
        check({tag, "_tc"}, int'(tc), exp_tc);
        check({tag, "_ovf"}, int'(overflow), m_ovf);
        check({tag, "_unf"}, int'(underflow), m_unf);
    endtask

    // Inputs are already applied; advance one edge and compare 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input bit c, input bit e, input bit u, input cnt_mode_e m,
                         input bit l, input int lv, input int ps);
        clear    = c;
        enable   = e;
        up_dn    = u;
        mode     = m;
        load     = l;
        load_val = WIDTH'(lv);
        prescale = PS_W'(ps);
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_count"}, int'(count), 0);
        check({tag, "_rst_ovf"}, int'(overflow), 0);
        check({tag, "_rst_unf"}, int'(underflow), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 1, CM_WRAP, 0, 0, 0);
        #12;
        check_outputs("reset");
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: wrap up-count through 9 -> 0
        drive(0, 1, 1, CM_WRAP, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc("t1");
        check("t1_final_count", int'(count), 0);
        check("t1_final_ovf", int'(overflow), 1);

        // T2: saturating down from 2
        drive(0, 0, 0, CM_SAT, 1, 2, 0);
        cyc("t2_load");
        drive(0, 1, 0, CM_SAT, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("t2");
        check("t2_final_count", int'(count), 0);
        check("t2_final_unf", int'(underflow), 1);

        // T3: prescale 3 with an enable gap
        drive(1, 0, 1, CM_WRAP, 0, 0, 3);
        cyc("t3_clr");
        drive(0, 1, 1, CM_WRAP, 0, 0, 3);
        for (int i = 0; i < 4; i++) cyc("t3a");
        enable = 1'b0;
        for (int i = 0; i < 2; i++) cyc("t3_hold");
        enable = 1'b1;
        for (int i = 0; i < 4; i++) cyc("t3b");
        check("t3_final_count", int'(count), 2);

        // T4: clamp, clear beats load, load beats tick
        drive(0, 0, 1, CM_WRAP, 1, 12, 0);
        cyc("t4_clamp");
        check("t4_clamp_count", int'(count), 9);
        drive(1, 0, 1, CM_WRAP, 1, 5, 0);
        cyc("t4_clr_load");
        check("t4_clr_load_count", int'(count), 0);
        drive(0, 0, 1, CM_WRAP, 1, 9, 0);
        cyc("t4_ld9");
        drive(0, 1, 1, CM_WRAP, 1, 3, 0);
        cyc("t4_ld_tick");
        check("t4_ld_tick_count", int'(count), 3);
        check("t4_ld_tick_ovf", int'(overflow), 0);

        // T5: async reset mid-cycle, from count 7 and from an overflow pulse
        drive(0, 0, 1, CM_WRAP, 1, 7, 0);
        cyc("t5_ld7");
        async_reset("t5a");
        drive(0, 1, 1, CM_WRAP, 0, 0, 0);
        cyc("t5_resume");
        check("t5_resume_count", int'(count), 1);
        drive(0, 0, 1, CM_WRAP, 1, 9, 0);
        cyc("t5_ld9");
        drive(0, 1, 1, CM_WRAP, 0, 0, 0);
        cyc("t5_wrap");
        async_reset("t5b");
        cyc("t5_resume2");

        // T6: wrap down from 0, then saturate at 0
        drive(1, 0, 0, CM_WRAP, 0, 0, 0);
        cyc("t6_clr");
        drive(0, 1, 0, CM_WRAP, 0, 0, 0);
        cyc("t6_wrap");
        check("t6_wrap_count", int'(count), MAX_VAL);
        check("t6_wrap_unf", int'(underflow), 1);
        drive(0, 0, 0, CM_SAT, 1, 0, 0);
        cyc("t6_ld0");
        drive(0, 1, 0, CM_SAT, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t6_sat");
        check("t6_sat_count", int'(count), 0);

        // Randomized traffic, including prescale changes that leave ps_cnt above the new target
        for (int i = 0; i < 3000; i++) begin
            clear    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = WIDTH'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 3) != 0);
            up_dn    = ($urandom_range(0, 9) < 6);
            mode     = cnt_mode_e'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) prescale = PS_W'($urandom_range(0, 7));
            cyc("rnd");
            check("rnd_excl", int'(overflow & underflow), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
